// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access widths, arbiter states,
// port indices and the request bundle routed through the selection mux.
package dm_arbiter_pkg;

   localparam logic [1:0] MEM_WIDTH4 = 2'd0;
   localparam logic [1:0] MEM_WIDTH2 = 2'd1;
   localparam logic [1:0] MEM_WIDTH1 = 2'd2;

   typedef enum logic {
      ARB_STATE_ARB   = 1'b0,
      ARB_STATE_BURST = 1'b1
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef struct packed {
      logic        we;
      logic [1:0]  width;
      logic        ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Saturating increment; the counter never passes its limit.
   function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] limit);
      logic [3:0] res;
      if (cnt >= limit) begin
         res = limit;
      end else begin
         res = cnt + 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_arb_mux.sv
// Routes the granted port's request onto the data-memory control/address/data
// inputs; with no grant every output is driven to zero.
module dm_arb_mux
   import dm_arbiter_pkg::*;
(
   input  logic        gnt_valid_i,
   input  logic        gnt_port_i,
   input  mem_req_t    m0_i,
   input  mem_req_t    m1_i,
   output logic        dm_we_o,
   output logic        dm_re_o,
   output logic [1:0]  dm_width_o,
   output logic        dm_ext_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wdata_o
);

   mem_req_t sel_s;

   // Select the winning request and derive the memory strobes from it.
   always_comb begin
      sel_s      = '0;
      dm_we_o    = 1'b0;
      dm_re_o    = 1'b0;
      dm_width_o = 2'd0;
      dm_ext_o   = 1'b0;
      dm_addr_o  = 32'd0;
      dm_wdata_o = 32'd0;
      if (gnt_valid_i) begin
         case (gnt_port_i)
            PORT_CPU: sel_s = m0_i;
            PORT_DMA: sel_s = m1_i;
            default:  sel_s = '0;
         endcase
         dm_we_o    = sel_s.we;
         dm_re_o    = ~sel_s.we;
         dm_width_o = sel_s.width;
         dm_ext_o   = sel_s.ext;
         dm_addr_o  = sel_s.addr;
         dm_wdata_o = sel_s.wdata;
      end else begin
         sel_s = '0;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage (port 0) and a DMA/debug
// loader (port 1): fixed CPU priority, starvation relief and bounded locked bursts.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [1:0]  m0_width,
   input  logic        m0_ext,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_stall,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [1:0]  m1_width,
   input  logic        m1_ext,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_lock,
   output logic        m1_gnt,
   output logic        r0_valid,
   output logic        r1_valid,
   output logic [31:0] r_data,
   output logic        r_exc,
   output logic        dm_we,
   output logic        dm_re,
   output logic [1:0]  dm_width,
   output logic        dm_ext,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_exc
);

   localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_LIMIT);
   localparam logic [7:0] BURST_MAX_C  = 8'(BURST_MAX);

   arb_state_e  state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [7:0]  beat_q, beat_d;
   logic        force_cpu_q, force_cpu_d;
   logic        r0_valid_q, r0_valid_d;
   logic        r1_valid_q, r1_valid_d;
   logic [31:0] r_data_q, r_data_d;
   logic        r_exc_q, r_exc_d;

   logic        gnt_cpu_s, gnt_dma_s, gnt_any_s;
   logic [7:0]  beat_inc_s;
   mem_req_t    m0_bus_s, m1_bus_s;

   assign m0_bus_s  = '{we: m0_we, width: m0_width, ext: m0_ext, addr: m0_addr, wdata: m0_wdata};
   assign m1_bus_s  = '{we: m1_we, width: m1_width, ext: m1_ext, addr: m1_addr, wdata: m1_wdata};
   assign gnt_any_s = gnt_cpu_s | gnt_dma_s;
   assign beat_inc_s = beat_q + 8'd1;

   // Grant decision, burst tracking and starvation bookkeeping.
   always_comb begin
      gnt_cpu_s   = 1'b0;
      gnt_dma_s   = 1'b0;
      state_d     = state_q;
      beat_d      = beat_q;
      force_cpu_d = 1'b0;
      case (state_q)
         ARB_STATE_ARB: begin
            beat_d = 8'd0;
            // A burst that ran to its length limit hands the next slot to the CPU.
            if (m0_req && (force_cpu_q || !((starve_q == STARVE_MAX_C) && m1_req))) begin
               gnt_cpu_s = 1'b1;
            end else if (m1_req) begin
               gnt_dma_s = 1'b1;
            end else begin
               gnt_cpu_s = 1'b0;
            end
            if (gnt_dma_s && m1_lock) begin
               if (BURST_MAX_C == 8'd1) begin
                  force_cpu_d = m0_req;
               end else begin
                  state_d = ARB_STATE_BURST;
                  beat_d  = 8'd1;
               end
            end else begin
               state_d = ARB_STATE_ARB;
            end
         end
         ARB_STATE_BURST: begin
            if (m1_req) begin
               gnt_dma_s = 1'b1;
               beat_d    = beat_inc_s;
               if (!m1_lock) begin
                  state_d = ARB_STATE_ARB;
               end else if (beat_inc_s == BURST_MAX_C) begin
                  state_d     = ARB_STATE_ARB;
                  force_cpu_d = m0_req;
               end else begin
                  state_d = ARB_STATE_BURST;
               end
            end else begin
               state_d = ARB_STATE_ARB;
            end
         end
         default: begin
            state_d = ARB_STATE_ARB;
            beat_d  = 8'd0;
         end
      endcase

      if (m1_req && !gnt_dma_s) begin
         starve_d = sat_inc4(starve_q, STARVE_MAX_C);
      end else begin
         starve_d = 4'd0;
      end
   end

   dm_arb_mux u_mux (
      .gnt_valid_i (gnt_any_s),
      .gnt_port_i  (gnt_dma_s ? PORT_DMA : PORT_CPU),
      .m0_i        (m0_bus_s),
      .m1_i        (m1_bus_s),
      .dm_we_o     (dm_we),
      .dm_re_o     (dm_re),
      .dm_width_o  (dm_width),
      .dm_ext_o    (dm_ext),
      .dm_addr_o   (dm_addr),
      .dm_wdata_o  (dm_wdata)
   );

   // Next-cycle response for whichever port won this cycle.
   always_comb begin
      r0_valid_d = gnt_cpu_s;
      r1_valid_d = gnt_dma_s;
      r_data_d   = 32'd0;
      r_exc_d    = 1'b0;
      if (gnt_any_s) begin
         r_exc_d  = dm_exc;
         r_data_d = dm_re ? dm_rdata : 32'd0;
      end else begin
         r_exc_d  = 1'b0;
         r_data_d = 32'd0;
      end
   end

   // State and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ARB_STATE_ARB;
         starve_q    <= 4'd0;
         beat_q      <= 8'd0;
         force_cpu_q <= 1'b0;
         r0_valid_q  <= 1'b0;
         r1_valid_q  <= 1'b0;
         r_data_q    <= 32'd0;
         r_exc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         beat_q      <= beat_d;
         force_cpu_q <= force_cpu_d;
         r0_valid_q  <= r0_valid_d;
         r1_valid_q  <= r1_valid_d;
         r_data_q    <= r_data_d;
         r_exc_q     <= r_exc_d;
      end
   end

   assign m0_stall = m0_req & ~gnt_cpu_s;
   assign m1_gnt   = gnt_dma_s;
   assign r0_valid = r0_valid_q;
   assign r1_valid = r1_valid_q;
   assign r_data   = r_data_q;
   assign r_exc    = r_exc_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a little-endian data-memory model
// (4 KiB, misaligned or out-of-range accesses raise an exception).
module tb_dm_arbiter;
   import dm_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_ext;
   logic [1:0]  m0_width;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_stall;
   logic        m1_req, m1_we, m1_ext, m1_lock;
   logic [1:0]  m1_width;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt;
   logic        r0_valid, r1_valid, r_exc;
   logic [31:0] r_data;
   logic        dm_we, dm_re, dm_ext;
   logic [1:0]  dm_width;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_exc;

   logic [31:0] mem [0:1023];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(8)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_width(m0_width), .m0_ext(m0_ext),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_width(m1_width), .m1_ext(m1_ext),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
      .r0_valid(r0_valid), .r1_valid(r1_valid), .r_data(r_data), .r_exc(r_exc),
      .dm_we(dm_we), .dm_re(dm_re), .dm_width(dm_width), .dm_ext(dm_ext),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_exc(dm_exc)
   );

   function automatic logic [31:0] rd_model(input logic [31:0] word, input logic [1:0] w,
                                            input logic e, input logic [1:0] lane);
      logic [15:0] h;
      logic [7:0]  b;
      h = lane[1] ? word[31:16] : word[15:0];
      b = word[{lane, 3'b000} +: 8];
      case (w)
         MEM_WIDTH4: return word;
         MEM_WIDTH2: return e ? {{16{h[15]}}, h} : {16'd0, h};
         MEM_WIDTH1: return e ? {{24{b[7]}}, b} : {24'd0, b};
         default:    return 32'd0;
      endcase
   endfunction

   function automatic logic exc_model(input logic [31:0] a, input logic [1:0] w);
      logic mis;
      case (w)
         MEM_WIDTH4: mis = (a[1:0] != 2'd0);
         MEM_WIDTH2: mis = a[0];
         MEM_WIDTH1: mis = 1'b0;
         default:    mis = 1'b1;
      endcase
      return mis || (a >= 32'h0000_1000);
   endfunction

   always_comb begin
      dm_rdata = 32'd0;
      dm_exc   = 1'b0;
      if (dm_re || dm_we) dm_exc = exc_model(dm_addr, dm_width);
      if (dm_re) dm_rdata = rd_model(mem[dm_addr[11:2]], dm_width, dm_ext, dm_addr[1:0]);
   end

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
         mem[4] <= 32'h1234_5678;
      end else if (dm_we && !dm_exc) begin
         case (dm_width)
            MEM_WIDTH4: mem[dm_addr[11:2]] <= dm_wdata;
            MEM_WIDTH2: mem[dm_addr[11:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_wdata[15:0];
            MEM_WIDTH1: mem[dm_addr[11:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wdata[7:0];
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [1:0] w,
                         input logic e, input logic [31:0] a, input logic [31:0] d);
      m0_req = req; m0_we = we; m0_width = w; m0_ext = e; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [1:0] w,
                         input logic lk, input logic [31:0] a, input logic [31:0] d);
      m1_req = req; m1_we = we; m1_width = w; m1_ext = 1'b0; m1_lock = lk;
      m1_addr = a; m1_wdata = d;
   endtask

   initial begin
      logic [10:0] exp_dma;
      int          beat;
      int          r1_pulses;
      reset = 1'b0;
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      set_m1(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);

      // Reset values
      #2;
      chk("rst_r0_valid", r0_valid, 1'b0);
      chk("rst_r1_valid", r1_valid, 1'b0);
      chk("rst_r_data", r_data, 32'd0);
      chk("rst_r_exc", r_exc, 1'b0);
      chk("rst_dm_we", dm_we, 1'b0);
      chk("rst_dm_re", dm_re, 1'b0);

      // Start a locked DMA burst, then pull reset at beat count 3
      @(negedge clk);
      reset = 1'b1;
      set_m1(1'b1, 1'b1, MEM_WIDTH4, 1'b1, 32'h100, 32'h1);
      #1;
      chk("burst0_gnt", m1_gnt, 1'b1);
      chk("burst0_dm_we", dm_we, 1'b1);
      chk("burst0_dm_addr", dm_addr, 32'h100);
      @(negedge clk); #1;
      chk("burst1_gnt", m1_gnt, 1'b1);
      chk("burst1_r1", r1_valid, 1'b1);
      @(negedge clk); #1;
      chk("burst2_gnt", m1_gnt, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      set_m0(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h10, 32'd0);
      #1;
      chk("midrst_r0", r0_valid, 1'b0);
      chk("midrst_r1", r1_valid, 1'b0);
      chk("midrst_dm_we", dm_we, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("postrst_m1_gnt", m1_gnt, 1'b0);
      chk("postrst_m0_stall", m0_stall, 1'b0);
      chk("postrst_r1", r1_valid, 1'b0);
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      set_m1(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      #1;
      chk("postrst_read_r0", r0_valid, 1'b1);
      chk("postrst_read_data", r_data, 32'h1234_5678);

      // CPU sign-extended halfword read at 0x12
      @(negedge clk);
      set_m0(1'b1, 1'b0, MEM_WIDTH2, 1'b1, 32'h12, 32'd0);
      #1;
      chk("half_stall", m0_stall, 1'b0);
      chk("half_dm_re", dm_re, 1'b1);
      chk("half_dm_addr", dm_addr, 32'h12);
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      #1;
      chk("half_r0", r0_valid, 1'b1);
      chk("half_r1", r1_valid, 1'b0);
      chk("half_data", r_data, 32'h0000_1234);
      chk("half_exc", r_exc, 1'b0);

      // Both ports request continuously: DMA wins every fifth cycle
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         set_m0(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h10, 32'd0);
         set_m1(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h14, 32'd0);
         #1;
         chk($sformatf("starve_gnt_%0d", k), m1_gnt, (k % 5) == 4);
         chk($sformatf("starve_stall_%0d", k), m0_stall, (k % 5) == 4);
         if (k > 0) chk($sformatf("starve_r1_%0d", k), r1_valid, ((k - 1) % 5) == 4);
      end
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      set_m1(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);

      // Locked 10-beat DMA write burst against a requesting CPU
      exp_dma   = 11'b110_1111_1111;
      beat      = 0;
      r1_pulses = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         set_m0((c >= 1) && (c <= 8), 1'b0, MEM_WIDTH4, 1'b0, 32'h10, 32'd0);
         set_m1(1'b1, 1'b1, MEM_WIDTH4, beat != 9, 32'h40 + 32'(4 * beat),
                32'hCAFE_0000 + 32'(beat));
         #1;
         chk($sformatf("bst_gnt_%0d", c), m1_gnt, exp_dma[c]);
         chk($sformatf("bst_addr_%0d", c), dm_addr, exp_dma[c] ? 32'h40 + 32'(4 * beat) : 32'h10);
         if (c > 0) begin
            chk($sformatf("bst_r1_%0d", c), r1_valid, exp_dma[c - 1]);
            chk($sformatf("bst_r0_%0d", c), r0_valid, (c - 1) == 8);
            if (exp_dma[c - 1]) chk($sformatf("bst_rdata_%0d", c), r_data, 32'd0);
         end
         if (r1_valid) r1_pulses++;
         if (exp_dma[c]) beat++;
      end
      @(negedge clk);
      set_m1(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      set_m0(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h5C, 32'd0);
      #1;
      if (r1_valid) r1_pulses++;
      chk("bst_last_r1", r1_valid, 1'b1);
      chk("bst_r1_pulses", 32'(r1_pulses), 32'd10);
      chk("readback_stall", m0_stall, 1'b0);
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      #1;
      chk("readback_r0", r0_valid, 1'b1);
      chk("readback_data", r_data, 32'hCAFE_0007);

      // DMA write then CPU read of the same word on the next cycle
      @(negedge clk);
      set_m1(1'b1, 1'b1, MEM_WIDTH4, 1'b0, 32'h20, 32'hDEAD_BEEF);
      #1;
      chk("raw_dma_gnt", m1_gnt, 1'b1);
      chk("raw_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      set_m1(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      set_m0(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h20, 32'd0);
      #1;
      chk("raw_cpu_stall", m0_stall, 1'b0);
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      #1;
      chk("raw_r0", r0_valid, 1'b1);
      chk("raw_data", r_data, 32'hDEAD_BEEF);

      // Misaligned, out-of-range CPU word read reports an exception
      @(negedge clk);
      set_m0(1'b1, 1'b0, MEM_WIDTH4, 1'b0, 32'h1002, 32'd0);
      @(negedge clk);
      set_m0(1'b0, 1'b0, MEM_WIDTH4, 1'b0, 32'd0, 32'd0);
      #1;
      chk("exc_r0", r0_valid, 1'b1);
      chk("exc_flag", r_exc, 1'b1);
      @(negedge clk); #1;
      chk("idle_r0", r0_valid, 1'b0);
      chk("idle_exc", r_exc, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
